// File: rtl/ntt_addr_gen.sv
// Butterfly operand sequencer for forward/inverse NTT over a 2^LOGN coefficient bank.
// Emits one (addr_a, addr_b, twiddle) descriptor per valid/ready handshake, with drain bubbles between layers.
module ntt_addr_gen #(
    parameter int LOGN         = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            inverse_i,
    input  logic            sel_red_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [LOGN-1:0] addr_a_o,
    output logic [LOGN-1:0] addr_b_o,
    output logic [LOGN-1:0] twiddle_idx_o,
    output logic            twiddle_neg_o,
    output logic            sel_butterfly_o,
    output logic            sel_red_o,
    output logic            last_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int HW = LOGN - 1;
    localparam int LW = $clog2(LOGN);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   layer_q, layer_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            inv_q, inv_d;
    logic            red_q, red_d;

    logic [HW-1:0]   mask;
    logic [HW-1:0]   grp;
    logic [LOGN-1:0] len;
    logic [LOGN-1:0] pow;
    logic [LOGN-1:0] grp_w;
    logic [LOGN-1:0] addr_a;
    logic [LOGN-1:0] addr_b;
    logic [LOGN-1:0] tw_idx;
    logic [LW-1:0]   layer_last;
    logic [LW-1:0]   layer_next;
    logic [LW-1:0]   layer_first;
    logic            run;
    logic            hs;
    logic            layer_end;
    logic            final_layer;
    logic            drain_end;

    // len = 2^(HW-l); the counter's low bits are the offset, its high bits the group,
    // so addr_a is the counter with a zero slot inserted at the len bit position.
    always_comb begin
        mask   = {HW{1'b1}} >> layer_q;
        grp    = cnt_q >> (LW'(HW) - layer_q);
        len    = {1'b0, mask} + LOGN'(1);
        pow    = LOGN'(1) << layer_q;
        grp_w  = {1'b0, grp};
        addr_a = {cnt_q & ~mask, 1'b0} | {1'b0, cnt_q & mask};
        addr_b = addr_a | len;
        tw_idx = inv_q ? (pow | (~grp_w & (pow - LOGN'(1)))) : (pow | grp_w);
    end

    assign run         = (state_q == S_RUN);
    assign hs          = run & ready_i;
    assign layer_end   = (cnt_q == {HW{1'b1}});
    assign layer_last  = red_q ? LW'(LOGN - 2) : LW'(LOGN - 1);
    assign final_layer = inv_q ? (layer_q == '0) : (layer_q == layer_last);
    assign layer_next  = inv_q ? (layer_q - LW'(1)) : (layer_q + LW'(1));
    assign layer_first = inverse_i ? (sel_red_i ? LW'(LOGN - 2) : LW'(LOGN - 1)) : '0;
    assign drain_end   = (drain_q == DW'(DRAIN_CYCLES - 1));

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        layer_d = layer_q;
        drain_d = drain_q;
        inv_d   = inv_q;
        red_d   = red_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    inv_d   = inverse_i;
                    red_d   = sel_red_i;
                    layer_d = layer_first;
                    cnt_d   = '0;
                    drain_d = '0;
                end
            end
            S_RUN: begin
                if (hs) begin
                    if (layer_end) begin
                        cnt_d = '0;
                        if (DRAIN_CYCLES == 0) begin
                            if (final_layer) begin
                                state_d = S_DONE;
                            end else begin
                                layer_d = layer_next;
                            end
                        end else begin
                            state_d = S_DRAIN;
                            drain_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + HW'(1);
                    end
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + DW'(1);
                if (drain_end) begin
                    drain_d = '0;
                    if (final_layer) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        layer_d = layer_next;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                layer_d = '0;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            layer_q <= '0;
            drain_q <= '0;
            inv_q   <= 1'b0;
            red_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            layer_q <= layer_d;
            drain_q <= drain_d;
            inv_q   <= inv_d;
            red_q   <= red_d;
        end
    end

    assign valid_o         = run;
    assign addr_a_o        = run ? addr_a : '0;
    assign addr_b_o        = run ? addr_b : '0;
    assign twiddle_idx_o   = run ? tw_idx : '0;
    assign twiddle_neg_o   = run & inv_q & ~red_q;
    assign sel_butterfly_o = inv_q;
    assign sel_red_o       = red_q;
    assign last_o          = run & final_layer & layer_end;
    assign busy_o          = run | (state_q == S_DRAIN);
    assign done_o          = (state_q == S_DONE);

endmodule
